// File: rtl/bit_packer.sv
// Packs variable-length fields (0..15 bits) MSB-first into 32-bit words, with
// flush of partial words and valid/stop flow control on both sides.
module bit_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        pushin,
    input  logic [3:0]  lenin,
    input  logic [14:0] datain,
    input  logic        flushin,
    input  logic        stopin,
    output logic        stopout,
    output logic        pushout,
    output logic [31:0] dataout,
    output logic [5:0]  lenout
);

    // Handshake: a field/flush is taken when pushin & !stopout; a word leaves
    // when pushout & !stopin. Both are evaluated against registered state.

    logic [46:0] acc;
    logic [46:0] acc_next;
    logic [46:0] acc_base;
    logic [46:0] field_ext;
    logic [5:0]  cnt;
    logic [5:0]  cnt_next;
    logic [5:0]  cnt_base;
    logic [5:0]  field_shift;
    logic [14:0] field_mask;
    logic        fp;
    logic        fp_next;
    logic        accept;
    logic        slot_free;
    logic        move;
    logic        flush_emit;
    logic        flush_empty;

    assign stopout     = (cnt > 6'd32) | fp;
    assign accept      = pushin & ~stopout;
    assign slot_free   = ~pushout | ~stopin;
    assign move        = (cnt >= 6'd32) & slot_free;
    assign flush_emit  = fp & (cnt != 6'd0) & (cnt < 6'd32) & slot_free;
    assign flush_empty = fp & (cnt == 6'd0);

    // Stored bits sit left-justified in acc; bits past cnt are kept zero so a
    // new field can simply be OR-ed in after them.
    always_comb begin
        acc_base = acc;
        cnt_base = cnt;
        if (move) begin
            acc_base = acc << 32;
            cnt_base = cnt - 6'd32;
        end else if (flush_emit) begin
            acc_base = '0;
            cnt_base = '0;
        end

        field_mask  = 15'((16'd1 << lenin) - 16'd1);
        field_ext   = {32'd0, datain & field_mask};
        field_shift = 6'd47 - cnt_base - {2'b00, lenin};

        acc_next = acc_base;
        cnt_next = cnt_base;
        if (accept) begin
            acc_next = acc_base | (field_ext << field_shift);
            cnt_next = cnt_base + {2'b00, lenin};
        end

        fp_next = fp;
        if (accept & flushin) begin
            fp_next = 1'b1;
        end else if (flush_emit | flush_empty) begin
            fp_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            cnt     <= '0;
            fp      <= 1'b0;
            pushout <= 1'b0;
            dataout <= '0;
            lenout  <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            fp  <= fp_next;
            if (move | flush_emit) begin
                pushout <= 1'b1;
                dataout <= acc[46:15];
                lenout  <= move ? 6'd32 : cnt;
            end else if (pushout & ~stopin) begin
                pushout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Directed and randomized checks of bit_packer against a bit-queue model of
// the packed stream.
module tb_bit_packer;

    logic        clock;
    logic        reset;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flushin;
    logic        stopin;
    logic        stopout;
    logic        pushout;
    logic [31:0] dataout;
    logic [5:0]  lenout;

    int checks = 0;
    int failures = 0;

    bit          bitq[$];
    logic [37:0] exp_q[$];
    logic [37:0] got_q[$];

    bit_packer dut (
        .clock   (clock),
        .reset   (reset),
        .pushin  (pushin),
        .lenin   (lenin),
        .datain  (datain),
        .flushin (flushin),
        .stopin  (stopin),
        .stopout (stopout),
        .pushout (pushout),
        .dataout (dataout),
        .lenout  (lenout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic emit(input int n);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[31-k] = bitq.pop_front();
        exp_q.push_back({6'(n), w});
    endtask

    // The stream model: bits in acceptance order; each 32 bits form a word,
    // and a flush closes whatever is left as a partial word.
    task automatic model_accept(input logic [3:0] l, input logic [14:0] d, input logic f);
        for (int i = int'(l) - 1; i >= 0; i--) bitq.push_back(d[i]);
        while (bitq.size() >= 32) emit(32);
        if (f && bitq.size() > 0) emit(bitq.size());
    endtask

    task automatic cyc(input logic p, input logic [3:0] l, input logic [14:0] d,
                       input logic f, input logic s, output logic took);
        @(negedge clock);
        pushin  = p;
        lenin   = l;
        datain  = d;
        flushin = f;
        stopin  = s;
        #1;
        if (pushout === 1'b1 && stopin === 1'b0) begin
            got_q.push_back({lenout, dataout});
            if (exp_q.size() == 0) chk("spurious_word", 64'(pushout), 64'(0));
            else chk("word", {26'd0, lenout, dataout}, {26'd0, exp_q.pop_front()});
        end
        took = p & ~stopout;
        if (took) model_accept(l, d, f);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic s);
        logic t;
        cyc(1'b0, 4'd0, 15'd0, 1'b0, s, t);
    endtask

    task automatic push_wait(input logic [3:0] l, input logic [14:0] d, input logic f, input logic s);
        logic t;
        t = 1'b0;
        for (int i = 0; i < 40 && !t; i++) cyc(1'b1, l, d, f, s, t);
        if (!t) chk("push_timeout", 64'(t), 64'(1));
    endtask

    task automatic drain();
        push_wait(4'd0, 15'd0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && (exp_q.size() > 0 || pushout === 1'b1); i++) idle(1'b0);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic        t;
        logic [14:0] fd[3];
        int          k;

        reset = 1'b0;
        pushin = 1'b0; lenin = '0; datain = '0; flushin = 1'b0; stopin = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pushout", 64'(pushout), 64'(0));
        chk("rst_dataout", 64'(dataout), 64'(0));
        chk("rst_lenout",  64'(lenout),  64'(0));
        chk("rst_stopout", 64'(stopout), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        // Eight nibbles make exactly one word
        got_q.delete();
        for (int i = 1; i <= 8; i++) push_wait(4'd4, 15'(i), 1'b0, 1'b0);
        chk("nib_not_yet", 64'(pushout), 64'(0));
        chk("nib_stopout", 64'(stopout), 64'(0));
        idle(1'b0);
        chk("nib_pushout", 64'(pushout), 64'(1));
        chk("nib_dataout", 64'(dataout), 64'h12345678);
        chk("nib_lenout",  64'(lenout),  64'(32));
        idle(1'b0);
        chk("nib_one_cycle", 64'(pushout), 64'(0));
        chk("nib_count", 64'(got_q.size()), 64'(1));

        // Fields straddling a word boundary, then flush
        got_q.delete();
        repeat (3) push_wait(4'd15, 15'h7FFF, 1'b0, 1'b0);
        drain();
        chk("strad_count", 64'(got_q.size()), 64'(2));
        if (got_q.size() == 2) begin
            chk("strad_w0", 64'(got_q[0]), {26'd0, 6'd32, 32'hFFFFFFFF});
            chk("strad_w1", 64'(got_q[1]), {26'd0, 6'd13, 32'hFFF80000});
        end

        // Downstream stall: output held, input stalls at high fill, no loss
        got_q.delete();
        for (int i = 0; i < 3; i++) push_wait(4'd15, 15'($urandom), 1'b0, 1'b1);
        chk("bp_stopout_45", 64'(stopout), 64'(1));
        for (int i = 0; i < 3; i++) fd[i] = 15'($urandom);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 4'd15, fd[k], 1'b0, 1'b1, t);
            if (t) k++;
            chk("bp_hold", {31'd0, pushout, dataout}, {31'd0, 1'b1, exp_q[0][31:0]});
        end
        chk("bp_accepted", 64'(k), 64'(2));
        chk("bp_stopout", 64'(stopout), 64'(1));
        chk("bp_lenout", 64'(lenout), 64'(32));
        for (int i = k; i < 3; i++) push_wait(4'd15, fd[i], 1'b0, 1'b0);
        drain();
        chk("bp_words", 64'(got_q.size()), 64'(3));

        // Field with flush in the same cycle
        got_q.delete();
        push_wait(4'd5, 15'h16, 1'b1, 1'b0);
        chk("fl_stopout_fp", 64'(stopout), 64'(1));
        chk("fl_not_yet", 64'(pushout), 64'(0));
        idle(1'b0);
        chk("fl_pushout", 64'(pushout), 64'(1));
        chk("fl_dataout", 64'(dataout), 64'hB0000000);
        chk("fl_lenout",  64'(lenout),  64'(5));
        chk("fl_stopout_clr", 64'(stopout), 64'(0));
        idle(1'b0);

        // Empty flush and zero-length fields
        got_q.delete();
        push_wait(4'd0, 15'h7FFF, 1'b0, 1'b0);
        push_wait(4'd0, 15'h7FFF, 1'b1, 1'b0);
        chk("ef_stopout_fp", 64'(stopout), 64'(1));
        idle(1'b0);
        chk("ef_stopout_clr", 64'(stopout), 64'(0));
        repeat (3) idle(1'b0);
        chk("ef_no_word", 64'(got_q.size()), 64'(0));
        chk("ef_pushout", 64'(pushout), 64'(0));
        for (int i = 1; i <= 8; i++) begin
            push_wait(4'd0, 15'($urandom), 1'b0, 1'b0);
            push_wait(4'd4, 15'(i), 1'b0, 1'b0);
        end
        repeat (2) idle(1'b0);
        chk("zl_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() == 1) chk("zl_word", 64'(got_q[0]), {26'd0, 6'd32, 32'h12345678});

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 15'($urandom),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0), t);
        end
        drain();

        // Asynchronous reset while a word is pending
        for (int i = 1; i <= 8; i++) push_wait(4'd4, 15'(i), 1'b0, 1'b1);
        push_wait(4'd7, 15'h55, 1'b0, 1'b1);
        idle(1'b1);
        chk("mr_pre_pushout", 64'(pushout), 64'(1));
        pushin = 1'b0;
        stopin = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("mr_pushout", 64'(pushout), 64'(0));
        chk("mr_dataout", 64'(dataout), 64'(0));
        chk("mr_lenout",  64'(lenout),  64'(0));
        chk("mr_stopout", 64'(stopout), 64'(0));
        bitq.delete();
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (5) idle(1'b0);
        chk("mr_no_glitch", 64'(pushout), 64'(0));
        for (int i = 1; i <= 8; i++) push_wait(4'd4, 15'(9 - i), 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        chk("mr_final_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
